// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Decodes hazards from the instruction in decode, resolves them by priority
// (memory wait > redirect > load-use / mul-div), and owns the mul/div busy
// window through a 6-bit down-counter. Also counts decode-stall cycles.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [31:0] i_data_instrD,
  input  logic        i_con_validD,
  input  logic [4:0]  i_addr_rtE,
  input  logic        i_con_memreadE,
  input  logic        i_con_branch_takenE,
  input  logic [1:0]  i_con_jumpD,
  input  logic        i_con_mem_ready,
  output logic        o_con_stallF,
  output logic        o_con_stallD,
  output logic        o_con_stallE,
  output logic        o_con_stallM,
  output logic        o_con_flushD,
  output logic        o_con_flushE,
  output logic        o_con_md_start,
  output logic [1:0]  o_con_md_op,
  output logic        o_con_md_busy,
  output logic [31:0] o_cnt_stall
);

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT);

  logic [5:0]  r_md_cnt;
  logic [31:0] r_cnt_stall;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [5:0]  w_funct;
  logic        w_md_opD;
  logic        w_hilo_rdD;
  logic        w_redirect;
  logic        w_load_use;
  logic        w_md_haz;

  assign w_op    = i_data_instrD[31:26];
  assign w_rs    = i_data_instrD[25:21];
  assign w_rt    = i_data_instrD[20:16];
  assign w_funct = i_data_instrD[5:0];

  // mult/multu/div/divu occupy funct 0x18..0x1B; mfhi/mflo are 0x10/0x12
  assign w_md_opD   = i_con_validD && (w_op == 6'd0) && (w_funct[5:2] == 4'b0110);
  assign w_hilo_rdD = i_con_validD && (w_op == 6'd0) &&
                      ((w_funct == 6'h10) || (w_funct == 6'h12));

  assign w_redirect = i_con_branch_takenE || (i_con_jumpD != 2'b00);
  assign w_load_use = i_con_validD && i_con_memreadE && (i_addr_rtE != 5'd0) &&
                      ((i_addr_rtE == w_rs) || (i_addr_rtE == w_rt));
  assign w_md_haz   = o_con_md_busy && (w_hilo_rdD || w_md_opD);

  assign o_con_md_busy = (r_md_cnt != 6'd0);
  assign o_cnt_stall   = r_cnt_stall;

  // Prioritised hazard resolution; flush/start are forced low while in reset
  always_comb begin
    o_con_stallF   = 1'b0;
    o_con_stallD   = 1'b0;
    o_con_stallE   = 1'b0;
    o_con_stallM   = 1'b0;
    o_con_flushD   = 1'b0;
    o_con_flushE   = 1'b0;
    o_con_md_start = 1'b0;
    o_con_md_op    = 2'b00;
    if (!i_con_mem_ready) begin
      // frozen pipeline keeps any pending redirect until memory answers
      o_con_stallF = 1'b1;
      o_con_stallD = 1'b1;
      o_con_stallE = 1'b1;
      o_con_stallM = 1'b1;
    end else if (w_redirect) begin
      o_con_flushD = i_nrst;
      o_con_flushE = i_nrst && i_con_branch_takenE;
    end else if (w_load_use || w_md_haz) begin
      o_con_stallF = 1'b1;
      o_con_stallD = 1'b1;
      o_con_flushE = i_nrst;
    end else if (w_md_opD && i_nrst) begin
      o_con_md_start = 1'b1;
      o_con_md_op    = w_funct[1:0];
    end
  end

  // Mul/div busy window: load latency on start, count down to zero otherwise
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_md_cnt <= 6'd0;
    end else if (o_con_md_start) begin
      r_md_cnt <= o_con_md_op[1] ? DIV_CNT : MUL_CNT;
    end else if (r_md_cnt != 6'd0) begin
      r_md_cnt <= r_md_cnt - 6'd1;
    end
  end

  // Saturating count of decode-stall cycles
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cnt_stall <= 32'd0;
    end else if (o_con_stallD && (r_cnt_stall != 32'hFFFF_FFFF)) begin
      r_cnt_stall <= r_cnt_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies directed and random
// cycles and pushes the reference model's expected outputs; a monitor pops
// and compares on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] instrD;
  logic        validD;
  logic [4:0]  rtE;
  logic        memreadE;
  logic        btE;
  logic [1:0]  jumpD;
  logic        mem_ready;
  logic        stallF, stallD, stallE, stallM, flushD, flushE, md_start, md_busy;
  logic [1:0]  md_op;
  logic [31:0] cnt_stall;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_data_instrD(instrD), .i_con_validD(validD),
    .i_addr_rtE(rtE), .i_con_memreadE(memreadE), .i_con_branch_takenE(btE),
    .i_con_jumpD(jumpD), .i_con_mem_ready(mem_ready),
    .o_con_stallF(stallF), .o_con_stallD(stallD), .o_con_stallE(stallE),
    .o_con_stallM(stallM), .o_con_flushD(flushD), .o_con_flushE(flushE),
    .o_con_md_start(md_start), .o_con_md_op(md_op), .o_con_md_busy(md_busy),
    .o_cnt_stall(cnt_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sF, sD, sE, sM, fD, fE, start, busy;
    logic [1:0]  op;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  // reference model state: absolute cycle index, end of busy window, stall total
  longint cyc = 0;
  longint md_done = 0;
  longint m_cnt = 0;
  bit     forced = 0;

  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] MULTU = 32'h0000_0019;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MFLO  = 32'h0000_0012;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [5:0] funct);
    return {6'd0, rs, rt, 5'd3, 5'd0, funct};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle-time %0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: apply inputs after the edge, predict, advance model
  task automatic drive(input logic n, input logic [31:0] ins, input logic v,
                       input logic [4:0] rte, input logic mr, input logic bt,
                       input logic [1:0] jd, input logic rdy, input bit preload);
    exp_t e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    bit is_md, is_hilo, busy, redirect, lu;
    @(posedge clk); #1;
    if (forced) begin release dut.r_cnt_stall; forced = 0; end
    nrst = n; instrD = ins; validD = v; rtE = rte; memreadE = mr;
    btE = bt; jumpD = jd; mem_ready = rdy;
    if (preload) begin
      force dut.r_cnt_stall = 32'hFFFF_FFFE;
      forced = 1;
      m_cnt = 64'hFFFF_FFFE;
    end
    if (!n) begin md_done = 0; m_cnt = 0; end
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; fn = ins[5:0];
    is_md    = v && op == 0 && fn >= 6'h18 && fn <= 6'h1B;
    is_hilo  = v && op == 0 && (fn == 6'h10 || fn == 6'h12);
    busy     = cyc < md_done;
    redirect = bt || jd != 0;
    lu       = v && mr && rte != 0 && (rte == rs || rte == rt);
    e = '{sF:0, sD:0, sE:0, sM:0, fD:0, fE:0, start:0, busy:busy, op:2'b00,
          cnt:m_cnt[31:0]};
    if (!rdy) begin
      e.sF = 1; e.sD = 1; e.sE = 1; e.sM = 1;
    end else if (redirect) begin
      e.fD = n; e.fE = n && bt;
    end else if (lu || (busy && (is_md || is_hilo))) begin
      e.sF = 1; e.sD = 1; e.fE = n;
    end else if (is_md && n) begin
      e.start = 1; e.op = fn[1:0];
    end
    exp_q.push_back(e);
    if (n) begin
      if (e.sD && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (e.start) md_done = cyc + 1 + (fn[1] ? DIV_LAT : MUL_LAT);
    end
    cyc++;
  endtask

  task automatic idle(input logic [31:0] ins);
    drive(1, ins, 1, 5'd0, 0, 0, 2'b00, 1, 0);
  endtask

  // Monitor: one expected entry per cycle, compared on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stallF", {31'd0, stallF}, {31'd0, e.sF});
      chk("stallD", {31'd0, stallD}, {31'd0, e.sD});
      chk("stallE", {31'd0, stallE}, {31'd0, e.sE});
      chk("stallM", {31'd0, stallM}, {31'd0, e.sM});
      chk("flushD", {31'd0, flushD}, {31'd0, e.fD});
      chk("flushE", {31'd0, flushE}, {31'd0, e.fE});
      chk("md_start", {31'd0, md_start}, {31'd0, e.start});
      chk("md_op", {30'd0, md_op}, {30'd0, e.op});
      chk("md_busy", {31'd0, md_busy}, {31'd0, e.busy});
      chk("cnt_stall", cnt_stall, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 0; instrD = 0; validD = 0; rtE = 0; memreadE = 0;
    btE = 0; jumpD = 0; mem_ready = 1;
    // reset, including a memory wait while in reset
    drive(0, 0, 0, 5'd0, 0, 0, 2'b00, 1, 0);
    drive(0, MULT, 1, 5'd0, 0, 1, 2'b01, 0, 0);
    drive(0, MULT, 1, 5'd0, 0, 0, 2'b00, 1, 0);
    // load-use: lw $8 in E, add $9,$8,$1 in D
    drive(1, rtype(5'd8, 5'd1, 6'h20), 1, 5'd8, 1, 0, 2'b00, 1, 0);
    idle(rtype(5'd8, 5'd1, 6'h20));
    // load into $0 never stalls
    drive(1, rtype(5'd0, 5'd0, 6'h20), 1, 5'd0, 1, 0, 2'b00, 1, 0);
    // mult then mfhi held for the busy window
    idle(MULT);
    for (int i = 0; i < 6; i++) idle(MFHI);
    // mfhi stalled when a taken branch arrives, then a squashed div
    idle(MULTU);
    idle(MFHI);
    drive(1, MFHI, 1, 5'd0, 0, 1, 2'b00, 1, 0);
    drive(1, DIV, 1, 5'd0, 0, 1, 2'b00, 1, 0);
    for (int i = 0; i < 4; i++) idle(0);
    // memory wait across a busy window with a pending jump
    idle(DIV);
    for (int i = 0; i < 26; i++) idle(0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 5'd0, 0, 0, 2'b01, 0, 0);
    drive(1, 0, 1, 5'd0, 0, 0, 2'b01, 1, 0);
    for (int i = 0; i < 4; i++) idle(0);
    // reset in the middle of a divide, then mflo is not stalled
    idle(DIV);
    for (int i = 0; i < 12; i++) idle(MFLO);
    drive(0, MFLO, 1, 5'd0, 0, 0, 2'b00, 1, 0);
    idle(MFLO);
    idle(MFLO);
    // stall counter saturation
    drive(1, 0, 0, 5'd0, 0, 0, 2'b00, 1, 1);
    for (int i = 0; i < 4; i++)
      drive(1, rtype(5'd5, 5'd0, 6'h20), 1, 5'd5, 1, 0, 2'b00, 1, 0);
    drive(0, 0, 0, 5'd0, 0, 0, 2'b00, 1, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      logic [4:0] rs, rt;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: ins = rtype(rs, rt, 6'h18);
        1: ins = rtype(rs, rt, 6'h19);
        2: ins = ($urandom_range(0, 3) == 0) ? rtype(rs, rt, 6'h1A) : rtype(rs, rt, 6'h20);
        3: ins = ($urandom_range(0, 3) == 0) ? rtype(rs, rt, 6'h1B) : rtype(rs, rt, 6'h22);
        4: ins = rtype(rs, rt, 6'h10);
        5: ins = rtype(rs, rt, 6'h12);
        6: ins = {6'h23, rs, rt, 16'h0004};
        7: ins = $urandom;
        default: ins = rtype(rs, rt, 6'h20);
      endcase
      drive($urandom_range(0, 199) != 0, ins, $urandom_range(0, 7) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0,
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom_range(0, 5) != 0, 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
    end
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
